if_stage: RTL

//  Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory.
//  - Owns the PC and drives the byte address into the combinational instruction memory.
//  - Latches the returned 32-bit word into the IF/ID pipeline register.
//  - Handles stall, branch/jump redirect with flush, PC wrap-around and a halt word.

---
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 102 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect and stall
// controls from decode, and the IF/ID register outputs.
interface if_stage_if;
    logic [31:0] instruction_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] adress_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    modport master (
        input  instruction_i, stall_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i,
        output adress_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
               halted_o, misalign_o, fetch_count_o
    );

    modport slave (
        output instruction_i, stall_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i,
        input  adress_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
               halted_o, misalign_o, fetch_count_o
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, latches IF/ID, and handles
// stall, branch/jump redirect with flush, PC wrap-around and a halt word.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 64,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    if_stage_if.master  bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic        misalign;
    logic [31:0] count;

    logic [31:0] pc_next;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;

    always_comb begin
        pc_next    = (pc + 32'd4) & ADDR_MASK;
        redirect   = bus.branch_taken_i | bus.jump_i;
        // Branch is from the older instruction, so it wins over the jump.
        target_raw = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;
        target     = target_raw & ADDR_MASK & ~32'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            instr    <= NOP_WORD;
            pc4      <= '0;
            valid    <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
            count    <= '0;
        end else begin
            misalign <= 1'b0;
            unique case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (redirect) begin
                        pc       <= target;
                        instr    <= NOP_WORD;
                        pc4      <= '0;
                        valid    <= 1'b0;
                        misalign <= |target_raw[1:0];
                    end else if (!bus.stall_i) begin
                        instr <= bus.instruction_i;
                        pc4   <= pc_next;
                        valid <= 1'b1;
                        if (count != '1)
                            count <= count + 32'd1;
                        // The halt word itself is delivered; the PC stays on it.
                        if (bus.instruction_i == HALT_WORD) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                HALT: begin
                    if (redirect) begin
                        pc       <= target;
                        instr    <= NOP_WORD;
                        pc4      <= '0;
                        valid    <= 1'b0;
                        misalign <= |target_raw[1:0];
                        halted   <= 1'b0;
                        state    <= RUN;
                    end else if (!bus.stall_i) begin
                        instr <= NOP_WORD;
                        pc4   <= '0;
                        valid <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.adress_o      = pc;
    assign bus.if_id_instr_o = instr;
    assign bus.if_id_pc4_o   = pc4;
    assign bus.if_id_valid_o = valid;
    assign bus.halted_o      = halted;
    assign bus.misalign_o    = misalign;
    assign bus.fetch_count_o = count;
endmodule
